// File: rtl/video_scan_doubler.sv
// ----------------------------------------------------------------------------
// video_scan_doubler
//
// Converts a 15 kHz source scanline stream into a 31 kHz VGA-style stream by
// writing each source line into one of two 1-bit line-buffer banks while the
// previously captured line is read out twice at double the pixel rate.
//
// Optional feature macro: SCANLINES_EN
//   When defined, the second output line of every pair is blanked (dark
//   alternate scanline). Sync outputs are unaffected.
//
// Ports
//   clk         in   system clock, all logic on the rising edge
//   reset       in   synchronous, active-high reset
//   pixel_en    in   one-clk strobe marking a valid source pixel
//   video_in    in   source pixel
//   h_sync_in   in   source horizontal sync, active high
//   v_sync_in   in   source vertical sync, active high
//   vga_video   out  doubled-rate pixel output
//   vga_h_sync  out  output horizontal sync, two pulses per source line
//   vga_v_sync  out  output vertical sync, updated at each output line start
// ----------------------------------------------------------------------------
module video_scan_doubler #(
    parameter int LINE_PIXELS   = 512,
    parameter int ACTIVE_PIXELS = 320,
    parameter int H_SYNC_START  = 400,
    parameter int H_SYNC_WIDTH  = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic pixel_en,
    input  logic video_in,
    input  logic h_sync_in,
    input  logic v_sync_in,
    output logic vga_video,
    output logic vga_h_sync,
    output logic vga_v_sync
);

    localparam int             AW   = $clog2(LINE_PIXELS);
    localparam logic [AW-1:0]  LAST = AW'(LINE_PIXELS - 1);

    typedef enum logic {RD_ACTIVE, RD_IDLE} rd_state_t;

    logic [LINE_PIXELS-1:0] bank_mem [2];

    logic          h_sync_q;
    logic          wr_bank;
    logic [AW-1:0] wr_x;
    logic [AW-1:0] rd_x;
    logic          rd_half;
    logic          valid;
    rd_state_t     rd_state;

    // First read stage: buffer bit plus the gating decisions for the same rd_x.
    logic          rd_bit;
    logic          vid_en_q;
    logic          hs_q;

    logic          line_start;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic          half_ok;
    logic          hs_window;
    logic          vid_window;

    // Rising edge of the source sync against its registered copy.
    assign line_start = h_sync_in & ~h_sync_q;

    // A pixel coincident with line start already belongs to the new line.
    assign wr_sel  = line_start ? ~wr_bank : wr_bank;
    assign wr_addr = line_start ? '0 : wr_x;

    assign hs_window  = (int'(rd_x) >= H_SYNC_START) &&
                        (int'(rd_x) <  H_SYNC_START + H_SYNC_WIDTH);
    assign vid_window = int'(rd_x) < ACTIVE_PIXELS;

`ifdef SCANLINES_EN
    assign half_ok = ~rd_half;
`else
    assign half_ok = 1'b1;
`endif

    // NOTE: the line buffers carry no reset; stale contents are harmless
    // because valid blanks video until a full line has been captured.
    always_ff @(posedge clk) begin
        if (!reset && pixel_en) begin
            bank_mem[wr_sel][wr_addr] <= video_in;
        end
    end

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the pre-edge values, exactly like the hardware flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_sync_q   <= 1'b0;
            wr_bank    <= 1'b0;
            wr_x       <= '0;
            rd_x       <= '0;
            rd_half    <= 1'b0;
            valid      <= 1'b0;
            rd_state   <= RD_ACTIVE;
            vga_v_sync <= 1'b0;
        end else begin
            h_sync_q <= h_sync_in;

            // Write side: address saturates on the last cell.
            if (line_start) begin
                wr_bank <= ~wr_bank;
                wr_x    <= pixel_en ? AW'(1) : '0;
            end else if (pixel_en && wr_x != LAST) begin
                wr_x <= wr_x + AW'(1);
            end

            // Read side FSM.
            if (line_start) begin
                rd_x       <= '0;
                rd_half    <= 1'b0;
                valid      <= 1'b1;
                rd_state   <= RD_ACTIVE;
                vga_v_sync <= v_sync_in;
            end else if (rd_state == RD_ACTIVE) begin
                if (rd_x != LAST) begin
                    rd_x <= rd_x + AW'(1);
                end else if (!rd_half) begin
                    rd_x       <= '0;
                    rd_half    <= 1'b1;
                    vga_v_sync <= v_sync_in;
                end else if (valid) begin
                    rd_state <= RD_IDLE;
                end else begin
                    // No line captured yet: keep free-running so the output
                    // still carries a regular horizontal sync.
                    rd_x       <= '0;
                    rd_half    <= 1'b0;
                    vga_v_sync <= v_sync_in;
                end
            end
        end
    end

    // Two-stage output pipeline: buffer read, then registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bit     <= 1'b0;
            vid_en_q   <= 1'b0;
            hs_q       <= 1'b0;
            vga_video  <= 1'b0;
            vga_h_sync <= 1'b0;
        end else begin
            rd_bit     <= bank_mem[~wr_bank][rd_x];
            vid_en_q   <= valid && (rd_state == RD_ACTIVE) && vid_window && half_ok;
            hs_q       <= (rd_state == RD_ACTIVE) && hs_window;
            vga_video  <= rd_bit & vid_en_q;
            vga_h_sync <= hs_q;
        end
    end

endmodule

// File: tb/tb_video_scan_doubler.sv
// ----------------------------------------------------------------------------
// tb_video_scan_doubler
//
// Scoreboard bench: the stimulus process advances a timeline-level reference
// model on every clock edge and queues the expected outputs; a monitor on the
// falling edge pops and compares against the DUT.
// ----------------------------------------------------------------------------
module tb_video_scan_doubler;

    localparam int LP  = 512;
    localparam int ACT = 320;
    localparam int HSS = 400;
    localparam int HSW = 40;

    logic clk = 1'b0;
    logic reset, pixel_en, video_in, h_sync_in, v_sync_in;
    logic vga_video, vga_h_sync, vga_v_sync;

    video_scan_doubler #(
        .LINE_PIXELS(LP), .ACTIVE_PIXELS(ACT),
        .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW)
    ) dut (
        .clk(clk), .reset(reset), .pixel_en(pixel_en), .video_in(video_in),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .vga_video(vga_video), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic video;
        logic hs;
    } pix_t;

    typedef struct packed {
        logic video;
        logic hs;
        logic vs;
    } exp_t;

    exp_t sb[$];

    int  tests = 0;
    int  fails = 0;
    int  cycle = 0;
    bit  done  = 1'b0;

    // Reference model: timeline position since the last line start.
    int   pos;
    bit   m_valid;
    bit   m_wbank;
    int   m_widx;
    bit   m_prev_h;
    bit   m_vs;
    bit   m_bank [2][LP];
    pix_t hist_a, hist_b;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cycle, act, exp);
        end
    endtask

    task automatic model_step();
        bit   ls, idle, half, half_ok;
        int   x;
        pix_t nxt;
        cycle++;
        if (reset) begin
            pos = 0; m_valid = 0; m_wbank = 0; m_widx = 0;
            m_prev_h = 0; m_vs = 0;
            hist_a = '0; hist_b = '0;
            sb.push_back('0);
            return;
        end
        ls = h_sync_in && !m_prev_h;
        m_prev_h = h_sync_in;
        if (ls) begin
            m_wbank = !m_wbank;
            m_widx  = 0;
            m_valid = 1;
            pos     = 0;
        end else begin
            pos++;
        end
        if (pixel_en) begin
            m_bank[m_wbank][m_widx] = video_in;
            if (m_widx < LP - 1) m_widx++;
        end
        x    = pos % LP;
        half = ((pos / LP) % 2) == 1;
        idle = m_valid && pos >= 2 * LP;
        if (ls || (!idle && pos > 0 && x == 0)) m_vs = v_sync_in;
`ifdef SCANLINES_EN
        half_ok = !half;
`else
        half_ok = 1'b1;
`endif
        nxt.video = (m_valid && !idle && x < ACT && half_ok) ? m_bank[!m_wbank][x] : 1'b0;
        nxt.hs    = !idle && x >= HSS && x < HSS + HSW;
        sb.push_back({hist_b.video, hist_b.hs, m_vs});
        hist_b = hist_a;
        hist_a = nxt;
    endtask

    // One clock: inputs already applied, model follows the edge.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        pixel_en = ~pixel_en;
    endtask

    task automatic quiet_cycles(input int n, input logic rst);
        for (int i = 0; i < n; i++) begin
            reset     = rst;
            h_sync_in = 1'b0;
            video_in  = 1'b1;
            step();
        end
    endtask

    // kind 0: only pixel 0 lit; 1: all ones; 2: random.
    task automatic source_line(input int len, input int kind, input int rst_at);
        int k = 0;
        int vs_flip = $urandom_range(len - 1, 0);
        for (int c = 0; c < len; c++) begin
            reset     = (c >= rst_at) && (c < rst_at + 2);
            h_sync_in = (c < 64);
            if (c == vs_flip && kind == 2) v_sync_in = ~v_sync_in;
            case (kind)
                0:       video_in = (k == 0);
                1:       video_in = 1'b1;
                default: video_in = $urandom_range(1, 0) == 1;
            endcase
            if (pixel_en) k++;
            step();
        end
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("vga_video",  vga_video,  e.video);
                check("vga_h_sync", vga_h_sync, e.hs);
                check("vga_v_sync", vga_v_sync, e.vs);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b1; pixel_en = 1'b0; video_in = 1'b1;
        h_sync_in = 1'b0; v_sync_in = 1'b0;
        quiet_cycles(3, 1'b1);
        // No line start: video blanked, free-running sync; fills bank 0.
        quiet_cycles(1600, 1'b0);
        v_sync_in = 1'b1;
        source_line(1024, 0, -10);   // single lit pixel
        v_sync_in = 1'b0;
        source_line(1024, 1, -10);   // all ones; shows single-pixel line
        source_line(1100, 2, -10);   // stretched; idle tail
        source_line(900,  2, -10);   // short; aborts read
        source_line(1024, 2, 300);   // reset mid-line
        for (int i = 0; i < 10; i++) begin
            source_line($urandom_range(1200, 500), 2, -10);
        end
        source_line(1024, 1, -10);
        quiet_cycles(1200, 1'b0);
        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_scan_doubler.md
VIDEO_SCAN_DOUBLER -- requirements
Module: video_scan_doubler

Interface
REQ-001 Parameter: LINE_PIXELS, 512, source pixels per scanline and buffer depth per bank (power of two).
REQ-002 Parameter: ACTIVE_PIXELS, 320, output pixels per line that may carry video.
REQ-003 Parameter: H_SYNC_START, 400, output pixel index at which vga_h_sync rises.
REQ-004 Parameter: H_SYNC_WIDTH, 40, vga_h_sync width in output pixels.
REQ-005 Port: clk  in  1  system clock, 16 MHz; single clock domain; all logic on rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: pixel_en  in  1  one-clk strobe marking a valid source pixel (8 MHz, every second clk).
REQ-008 Port: video_in  in  1  source pixel from the 15 kHz video generator.
REQ-009 Port: h_sync_in  in  1  source horizontal sync, active high.
REQ-010 Port: v_sync_in  in  1  source vertical sync, active high.
REQ-011 Port: vga_video  out  1  doubled-rate pixel output.
REQ-012 Port: vga_h_sync  out  1  output horizontal sync, active high, two pulses per source line.
REQ-013 Port: vga_v_sync  out  1  output vertical sync, active high.

Function
REQ-014 Two line-buffer banks of LINE_PIXELS x 1 bit; write bank wr_bank, read bank !wr_bank.
REQ-015 Write: on clk with pixel_en=1, store video_in at wr_x in wr_bank, then wr_x+1; wr_x saturates at LINE_PIXELS-1 (no wrap, last cell rewritten).
REQ-016 Source line start = h_sync_in rising edge, detected against a registered copy (one-clk detect latency).
REQ-017 At line start: wr_x<=0, wr_bank toggles, rd_x<=0, rd_half<=0, valid<=1; coincident pixel_en writes to the new bank at address 0.
REQ-018 Read: rd_x increments every clk (one output pixel per clk, double source rate).
REQ-019 rd_x=LINE_PIXELS-1 with rd_half=0: rd_x<=0, rd_half<=1 (second output line, same buffer data).
REQ-020 rd_x=LINE_PIXELS-1 with rd_half=1: enter IDLE; rd_x holds, vga_video=0, vga_h_sync=0 until next line start.
REQ-021 Line start while reading (source line shorter than 2 x LINE_PIXELS output pixels) aborts current read and realigns per REQ-017.
REQ-022 Buffer read has one-clk latency; vga_video and vga_h_sync registered so both align with the pixel read at rd_x (total two clks from rd_x).
REQ-023 vga_video = buffer bit when valid=1, rd_x<ACTIVE_PIXELS and not IDLE, else 0.
REQ-024 vga_h_sync = 1 when H_SYNC_START <= rd_x < H_SYNC_START+H_SYNC_WIDTH and not IDLE; compare at full counter width, no wrap.
REQ-025 vga_v_sync = v_sync_in sampled at each output line start (rd_x reset to 0), held for the whole output line.
REQ-026 Output latency: data written during source line N appears on output lines 2N and 2N+1, during source line N+1.

Reset
REQ-027 Reset: wr_x=0, rd_x=0, rd_half=0, wr_bank=0, valid=0, sync-edge register=0, IDLE cleared.
REQ-028 Reset outputs: vga_video=0, vga_h_sync=0, vga_v_sync=0; buffer contents not cleared; valid=0 blanks vga_video until first line start.
REQ-029 Reset asserted mid-line wins over all other events in the same clk.

Configuration
REQ-030 Macro SCANLINES_EN: when defined, vga_video forced 0 whenever rd_half=1 (dark alternate scanline); sync outputs unaffected.
REQ-031 Without SCANLINES_EN, both output lines of a pair carry identical video.

Verification
REQ-032 Reset, then no h_sync_in edge, video_in=1 -> vga_video stays 0, vga_h_sync pulses 40 clks every 512 clks after idle? no: stays 0 (IDLE not entered, valid=0 blanks video; h_sync pulses at rd_x 400..439 each 512 clks).
REQ-033 Source line: pixel 0=1, pixels 1..511=0, 1024 clks per line -> next source line shows vga_video=1 at rd_x=0 of both halves, 0 elsewhere.
REQ-034 Source line of 1024 clks -> exactly two vga_h_sync pulses, each 40 clks, rising 400 and 912 clks (+2 latency) after line-start detect.
REQ-035 Source line stretched to 1100 clks -> IDLE for 76 clks, vga_video=0 and vga_h_sync=0 throughout.
REQ-036 v_sync_in rises mid output line -> vga_v_sync rises only at next rd_x=0.
REQ-037 SCANLINES_EN defined, all-ones source line -> second half shows vga_video=0, first half 1 for rd_x 0..319.
